// File: rtl/prog_store_pkg.sv
// Shared types and helpers for the loadable program store.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package prog_store_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } prog_state_e;

    // Widest CPU address the index helper handles.
    localparam int PS_ADDR_MAX = 64;

    function automatic int ps_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ps_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [PS_ADDR_MAX-1:0] word_index(input logic [PS_ADDR_MAX-1:0] byte_addr);
        return byte_addr >> 1;
    endfunction

endpackage

// File: rtl/prog_store_mem.sv
// Instruction word array: one synchronous write port, one registered read port.
module prog_store_mem #(
    parameter int DEPTH     = 128,
    parameter int WORD_SIZE = 16,
    parameter int AW        = 7
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_store.sv
// Loadable program store: streaming loader fills memory, then serves CPU fetches.
module prog_store
    import prog_store_pkg::*;
#(
    parameter int ADDR_SIZE = `ADDR_SIZE,
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int DEPTH     = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       boot,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [WORD_SIZE-1:0]       ld_data,
    input  logic                       ld_last,
    output logic                       load_done,
    output logic [ps_cnt_w(DEPTH)-1:0] load_count,
    output logic                       load_err,
    input  logic                       rd_req,
    input  logic [ADDR_SIZE-1:0]       addr,
    output logic                       rd_valid,
    output logic [WORD_SIZE-1:0]       rd_data,
    output logic                       rd_err,
    output logic                       data_oe
);

    localparam int PS_CNT_W = ps_cnt_w(DEPTH);
    localparam int AW       = ps_addr_w(DEPTH);
    localparam logic [PS_CNT_W-1:0] DEPTH_C = PS_CNT_W'(DEPTH);
    localparam logic [PS_CNT_W-1:0] LAST_C  = PS_CNT_W'(DEPTH - 1);
    localparam logic [ADDR_SIZE:0]  DEPTH_A = (ADDR_SIZE + 1)'(DEPTH);

    prog_state_e          state, state_nxt;
    logic                 accept;
    logic                 fetch;
    logic                 addr_ok;
    logic [ADDR_SIZE-1:0] idx;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        raddr;
    logic [DEPTH-1:0]     wvalid;
    logic                 rd_good;
    logic [WORD_SIZE-1:0] mem_q;

    assign idx     = ADDR_SIZE'(word_index(PS_ADDR_MAX'(addr)));
    assign addr_ok = ~addr[0] & ({1'b0, idx} < DEPTH_A);
    assign waddr   = AW'(load_count);
    assign raddr   = AW'(idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_LOAD && accept && (ld_last || load_count == LAST_C)) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        ld_ready  = (state == S_LOAD) && (load_count < DEPTH_C);
        load_done = (state == S_RUN);
        data_oe   = boot & (state == S_RUN);
        accept    = ld_valid & ld_ready;
        fetch     = rd_req & (state == S_RUN);
    end

    // Written-valid bits mask stale array contents so unwritten words read as 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count <= '0;
            wvalid     <= '0;
            load_err   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_good    <= 1'b0;
        end else begin
            if (accept) begin
                load_count    <= load_count + 1'b1;
                wvalid[waddr] <= 1'b1;
            end
            if (state == S_RUN && ld_valid) begin
                load_err <= 1'b1;
            end
            rd_valid <= fetch;
            rd_err   <= rd_req & ~(fetch & addr_ok);
            if (fetch) begin
                rd_good <= addr_ok & wvalid[raddr];
            end
        end
    end

    prog_store_mem #(
        .DEPTH    (DEPTH),
        .WORD_SIZE(WORD_SIZE),
        .AW       (AW)
    ) u_mem (
        .clk  (clk),
        .we   (accept),
        .waddr(waddr),
        .wdata(ld_data),
        .re   (fetch & addr_ok),
        .raddr(raddr),
        .rdata(mem_q)
    );

    assign rd_data = rd_good ? mem_q : '0;

endmodule

// File: tb/tb_prog_store.sv
// Directed bench: a default-depth store and a DEPTH=4 store share one stimulus stream.
module tb_prog_store;

    logic        clk = 1'b0;
    logic        reset, boot, ld_valid, ld_last, rd_req;
    logic [15:0] ld_data, addr;

    logic        a_ld_ready, a_load_done, a_load_err, a_rd_valid, a_rd_err, a_data_oe;
    logic [7:0]  a_load_count;
    logic [15:0] a_rd_data;
    logic        b_ld_ready, b_load_done, b_load_err, b_rd_valid, b_rd_err, b_data_oe;
    logic [2:0]  b_load_count;
    logic [15:0] b_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_store #(.ADDR_SIZE(16), .WORD_SIZE(16), .DEPTH(128)) u_a (
        .clk(clk), .reset(reset), .boot(boot), .ld_valid(ld_valid), .ld_ready(a_ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .load_done(a_load_done), .load_count(a_load_count),
        .load_err(a_load_err), .rd_req(rd_req), .addr(addr), .rd_valid(a_rd_valid),
        .rd_data(a_rd_data), .rd_err(a_rd_err), .data_oe(a_data_oe)
    );

    prog_store #(.ADDR_SIZE(16), .WORD_SIZE(16), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .boot(boot), .ld_valid(ld_valid), .ld_ready(b_ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .load_done(b_load_done), .load_count(b_load_count),
        .load_err(b_load_err), .rd_req(rd_req), .addr(addr), .rd_valid(b_rd_valid),
        .rd_data(b_rd_data), .rd_err(b_rd_err), .data_oe(b_data_oe)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; boot = 1'b1; ld_valid = 1'b0; ld_data = '0;
        ld_last = 1'b0; rd_req = 1'b0; addr = '0;
        cyc(); cyc();
        chk("rst_ld_ready", 32'(a_ld_ready), 32'd1);
        chk("rst_load_done", 32'(a_load_done), 32'd0);
        chk("rst_load_count", 32'(a_load_count), 32'd0);
        chk("rst_load_err", 32'(a_load_err), 32'd0);
        chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("rst_rd_err", 32'(a_rd_err), 32'd0);
        chk("rst_rd_data", 32'(a_rd_data), 32'd0);
        chk("rst_data_oe", 32'(a_data_oe), 32'd0);
        reset = 1'b0; boot = 1'b0;

        // Three-word load with ld_last, then back-to-back fetches
        ld_valid = 1'b1; ld_data = 16'h1205; cyc();
        ld_data = 16'h1612; cyc();
        ld_data = 16'hA000; ld_last = 1'b1; cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("t1_load_done", 32'(a_load_done), 32'd1);
        chk("t1_load_count", 32'(a_load_count), 32'd3);
        chk("t1_ld_ready_run", 32'(a_ld_ready), 32'd0);
        rd_req = 1'b1; addr = 16'd0; cyc();
        chk("t1_rd_valid0", 32'(a_rd_valid), 32'd1);
        chk("t1_rd_data0", 32'(a_rd_data), 32'h1205);
        chk("t1_rd_err0", 32'(a_rd_err), 32'd0);
        addr = 16'd2; cyc();
        chk("t1_rd_data2", 32'(a_rd_data), 32'h1612);
        addr = 16'd4; cyc();
        chk("t1_rd_data4", 32'(a_rd_data), 32'hA000);
        chk("t1_b_rd_data4", 32'(b_rd_data), 32'hA000);
        addr = 16'd3; cyc();
        chk("odd_rd_valid", 32'(a_rd_valid), 32'd1);
        chk("odd_rd_data", 32'(a_rd_data), 32'd0);
        chk("odd_rd_err", 32'(a_rd_err), 32'd1);
        addr = 16'd256; cyc();
        chk("range_rd_data", 32'(a_rd_data), 32'd0);
        chk("range_rd_err", 32'(a_rd_err), 32'd1);
        addr = 16'd10; cyc();
        chk("unwr_rd_data", 32'(a_rd_data), 32'd0);
        chk("unwr_rd_err", 32'(a_rd_err), 32'd0);
        chk("b_range10_err", 32'(b_rd_err), 32'd1);
        addr = 16'd2; cyc();
        rd_req = 1'b0; cyc();
        chk("idle_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("idle_rd_err", 32'(a_rd_err), 32'd0);
        chk("hold_rd_data", 32'(a_rd_data), 32'h1612);
        boot = 1'b1; #1;
        chk("oe_boot1_run", 32'(a_data_oe), 32'd1);
        boot = 1'b0; #1;
        chk("oe_boot0_run", 32'(a_data_oe), 32'd0);
        ld_valid = 1'b1; ld_data = 16'hDEAD; cyc();
        ld_valid = 1'b0;
        chk("run_load_err", 32'(a_load_err), 32'd1);
        chk("run_drop_count", 32'(a_load_count), 32'd3);
        cyc();
        chk("load_err_sticky", 32'(a_load_err), 32'd1);

        // DEPTH=4 store fills without ld_last
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("b_rst_load_err", 32'(b_load_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'(16'h0011 * (i + 1));
            chk($sformatf("b_ld_ready_%0d", i), 32'(b_ld_ready), (i < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        ld_valid = 1'b0;
        chk("b_full_count", 32'(b_load_count), 32'd4);
        chk("b_full_done", 32'(b_load_done), 32'd1);
        chk("b_full_err", 32'(b_load_err), 32'd1);
        chk("a_five_count", 32'(a_load_count), 32'd5);
        chk("a_five_done", 32'(a_load_done), 32'd0);
        rd_req = 1'b1; addr = 16'd6; cyc();
        rd_req = 1'b0;
        chk("b_word4_valid", 32'(b_rd_valid), 32'd1);
        chk("b_word4_data", 32'(b_rd_data), 32'h0044);
        chk("b_word4_err", 32'(b_rd_err), 32'd0);
        chk("a_load_fetch_valid", 32'(a_rd_valid), 32'd0);
        chk("a_load_fetch_err", 32'(a_rd_err), 32'd1);
        boot = 1'b1; #1;
        chk("oe_boot1_load", 32'(a_data_oe), 32'd0);
        chk("b_oe_boot1_run", 32'(b_data_oe), 32'd1);
        boot = 1'b0;

        // Loader stalls while fetches are requested in S_LOAD
        reset = 1'b1; cyc(); reset = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h0A01; rd_req = 1'b1; addr = 16'd0; cyc();
        chk("stall_count1", 32'(a_load_count), 32'd1);
        chk("stall_valid1", 32'(a_rd_valid), 32'd0);
        chk("stall_err1", 32'(a_rd_err), 32'd1);
        ld_valid = 1'b0; cyc();
        chk("stall_count_hold", 32'(a_load_count), 32'd1);
        chk("stall_err2", 32'(a_rd_err), 32'd1);
        ld_valid = 1'b1; ld_data = 16'h0A02; ld_last = 1'b1; cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("stall_count2", 32'(a_load_count), 32'd2);
        chk("stall_done", 32'(a_load_done), 32'd1);
        chk("stall_valid3", 32'(a_rd_valid), 32'd0);
        chk("stall_data_kept", 32'(a_rd_data), 32'd0);
        addr = 16'd2; cyc();
        rd_req = 1'b0;
        chk("stall_fetch_valid", 32'(a_rd_valid), 32'd1);
        chk("stall_fetch_data", 32'(a_rd_data), 32'h0A02);

        // Reset mid-load and mid-fetch, then reload
        reset = 1'b1; cyc(); reset = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h0C01; cyc();
        ld_data = 16'h0C02; cyc();
        ld_data = 16'h0C03; reset = 1'b1; cyc();
        reset = 1'b0; ld_valid = 1'b0;
        chk("midload_count", 32'(a_load_count), 32'd0);
        chk("midload_done", 32'(a_load_done), 32'd0);
        chk("midload_ready", 32'(a_ld_ready), 32'd1);
        ld_valid = 1'b1; ld_data = 16'h0BEE; ld_last = 1'b1; cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("pre_fetch_done", 32'(a_load_done), 32'd1);
        rd_req = 1'b1; addr = 16'd0; reset = 1'b1; cyc();
        reset = 1'b0; rd_req = 1'b0;
        chk("midfetch_valid", 32'(a_rd_valid), 32'd0);
        chk("midfetch_err", 32'(a_rd_err), 32'd0);
        chk("midfetch_data", 32'(a_rd_data), 32'd0);
        chk("midfetch_done", 32'(a_load_done), 32'd0);
        ld_valid = 1'b1; ld_data = 16'h0BEF; ld_last = 1'b1; cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        rd_req = 1'b1; addr = 16'd0; cyc();
        chk("reload_valid", 32'(a_rd_valid), 32'd1);
        chk("reload_data", 32'(a_rd_data), 32'h0BEF);
        addr = 16'd2; cyc();
        rd_req = 1'b0;
        chk("reload_stale_data", 32'(a_rd_data), 32'd0);
        chk("reload_stale_err", 32'(a_rd_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
